fft_output_serializer: RTL and testbench
========================================

FFT_OUTPUT_SERIALIZER -- requirements
Module: fft_output_serializer

Interface
REQ-001 Parameter N_POINTS, default 64, number of complex samples per frame.
REQ-002 Parameter LOG2_N, default 6, sample index width.
REQ-003 Parameter SAMPLE_W, default 16, bits per real or imaginary sample; frame bus width is N_POINTS*SAMPLE_W (1024).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 frame_valid  input  1  frame_re/frame_im hold a complete FFT result frame.
REQ-007 frame_ready  output  1  block can accept a frame this cycle.
REQ-008 frame_re, frame_im  input  1024 each  sample k occupies bits [k*16 +: 16], all 16 bits used.
REQ-009 bitrev_sel  input  1  0: emit in index order 0..63; 1: emit in 6-bit bit-reversed index order.
REQ-010 out_valid  output  1  out_re/out_im/out_index/out_last are valid.
REQ-011 out_ready  input  1  downstream accepts the current sample.
REQ-012 out_re, out_im  output  16 each  current sample.
REQ-013 out_index  output  6  frame index k of the sample on out_re/out_im.
REQ-014 out_last  output  1  high with the 64th sample of a frame.
REQ-015 busy  output  1  high while a frame is being streamed.

Function
REQ-016 Two states: IDLE (no frame held) and STREAM (frame held, emitting samples).
REQ-017 Frame handshake occurs when frame_valid && frame_ready; frame_re, frame_im and bitrev_sel are captured into internal registers that cycle.
REQ-018 frame_ready = (state == IDLE) || (out_valid && out_ready && out_last); combinational, no dependency on frame_valid.
REQ-019 IDLE -> STREAM on frame handshake; out_valid rises the following cycle with emission counter 0 (latency 1 cycle).
REQ-020 Emission counter advances by 1 per output handshake (out_valid && out_ready); no advance otherwise.
REQ-021 out_index = counter when captured bitrev_sel = 0; bit-reverse(counter) when 1.
REQ-022 out_re/out_im = captured sample at out_index.
REQ-023 out_last = out_valid && (counter == 63).
REQ-024 While out_valid && !out_ready, all outputs hold stable.
REQ-025 Handshake on out_last with no new frame: STREAM -> IDLE, out_valid = 0 next cycle, counter wraps to 0.
REQ-026 Handshake on out_last simultaneous with frame handshake: new frame captured, stays in STREAM, counter 0, out_valid stays high; no bubble; 64 cycles/frame sustained.
REQ-027 frame_valid during STREAM before final handshake: ignored (frame_ready low); upstream must hold.
REQ-028 bitrev_sel changes mid-frame have no effect on the frame in progress.
REQ-029 out_re, out_im, out_index, out_last driven to 0 whenever out_valid = 0.
REQ-030 busy = (state == STREAM).

Reset
REQ-031 rst_n low at a rising edge: state IDLE, counter 0, out_valid 0, captured bitrev_sel 0; frame buffer need not be cleared.
REQ-032 Reset mid-frame abandons the frame; first cycle after release frame_ready = 1, out_valid = 0.
REQ-033 Reset has priority over any simultaneous handshake.

Structure
REQ-034 Shared package fft_pkg holds N_POINTS, LOG2_N, SAMPLE_W, FRAME_W, the IDLE/STREAM state enum, and the 6-bit bit-reverse function shared with the input routing path.
REQ-035 One sub-module fft_frame_mux: combinational 64:1 selection of a 16-bit re/im pair from the 1024-bit buffers by 6-bit index.

Verification
REQ-036 Frame with re[k]=k, im[k]=-k, bitrev_sel=0, out_ready=1 -> out_valid 1 cycle after accept, outputs re 0..63 in order, out_last only on 63, then idle.
REQ-037 Same frame, bitrev_sel=1 -> out_index/out_re sequence 0,32,16,48,8,...,63; out_last on 64th sample (index 63).
REQ-038 out_ready toggled pseudo-randomly (50%) -> every sample emitted exactly once, outputs stable during stalls, 64 handshakes total.
REQ-039 Two frames back-to-back, frame_valid held, out_ready=1 -> second frame's sample 0 in cycle after first frame's out_last; 128 consecutive valid cycles.
REQ-040 rst_n low for 1 cycle after 10th sample -> out_valid 0, frame_ready 1 next cycle; a new frame then streams from index 0.
REQ-041 frame_valid pulsed during STREAM with different data -> ignored, current frame output unaltered.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants, serializer state encoding and the index bit-reverse
// helper that is also used by the input routing path.
package fft_pkg;

  localparam int N_POINTS = 64;
  localparam int LOG2_N   = 6;
  localparam int SAMPLE_W = 16;
  localparam int FRAME_W  = N_POINTS * SAMPLE_W;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Mirror the index bits: bit b of the result is bit LOG2_N-1-b of idx.
  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] idx);
    logic [LOG2_N-1:0] r;
    for (int b = 0; b < LOG2_N; b++) r[b] = idx[LOG2_N-1-b];
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_mux.sv
// Combinational selection of one re/im sample pair out of the captured
// frame buffers, addressed by the sample index.
module fft_frame_mux #(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int LOG2_N   = fft_pkg::LOG2_N,
  parameter int SAMPLE_W = fft_pkg::SAMPLE_W
) (
  input  logic [N_POINTS*SAMPLE_W-1:0] frame_re,
  input  logic [N_POINTS*SAMPLE_W-1:0] frame_im,
  input  logic [LOG2_N-1:0]            index,
  output logic [SAMPLE_W-1:0]          re,
  output logic [SAMPLE_W-1:0]          im
);
  import fft_pkg::*;

  // Packed array view: element k is bits [k*SAMPLE_W +: SAMPLE_W].
  logic [N_POINTS-1:0][SAMPLE_W-1:0] re_arr, im_arr;

  assign re_arr = frame_re;
  assign im_arr = frame_im;
  assign re     = re_arr[index];
  assign im     = im_arr[index];

endmodule

// File: rtl/fft_output_serializer.sv
// Captures a full FFT result frame and streams it out one complex sample per
// handshake, in natural or bit-reversed index order.
module fft_output_serializer #(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int LOG2_N   = fft_pkg::LOG2_N,
  parameter int SAMPLE_W = fft_pkg::SAMPLE_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  input  logic [N_POINTS*SAMPLE_W-1:0] frame_re,
  input  logic [N_POINTS*SAMPLE_W-1:0] frame_im,
  input  logic                         bitrev_sel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SAMPLE_W-1:0]          out_re,
  output logic [SAMPLE_W-1:0]          out_im,
  output logic [LOG2_N-1:0]            out_index,
  output logic                         out_last,
  output logic                         busy
);
  import fft_pkg::*;

  localparam int FW = N_POINTS * SAMPLE_W;

  state_e              state, state_nxt;
  logic [LOG2_N-1:0]   cnt, cnt_nxt;
  logic                brev;
  logic [FW-1:0]       re_buf, im_buf;
  logic                out_hs, frame_hs, at_last;
  logic [LOG2_N-1:0]   idx;
  logic [SAMPLE_W-1:0] mux_re, mux_im;

  assign out_valid   = (state == STREAM);
  assign busy        = (state == STREAM);
  assign at_last     = out_valid && (cnt == LOG2_N'(N_POINTS - 1));
  assign out_hs      = out_valid && out_ready;
  // A new frame may land in the same cycle the last sample leaves: no bubble.
  assign frame_ready = (state == IDLE) || (out_hs && at_last);
  assign frame_hs    = frame_valid && frame_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (frame_hs) begin
      state_nxt = STREAM;
      cnt_nxt   = '0;
    end else if (out_hs) begin
      cnt_nxt = cnt + 1'b1;
      if (at_last) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      brev  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (frame_hs) brev <= bitrev_sel;
    end
  end

  // Frame buffer carries no reset; contents are only observed while streaming.
  always_ff @(posedge clk) begin
    if (frame_hs) begin
      re_buf <= frame_re;
      im_buf <= frame_im;
    end
  end

  assign idx = brev ? bitrev(cnt) : cnt;

  fft_frame_mux #(
    .N_POINTS (N_POINTS),
    .LOG2_N   (LOG2_N),
    .SAMPLE_W (SAMPLE_W)
  ) u_mux (
    .frame_re (re_buf),
    .frame_im (im_buf),
    .index    (idx),
    .re       (mux_re),
    .im       (mux_im)
  );

  assign out_re    = out_valid ? mux_re : '0;
  assign out_im    = out_valid ? mux_im : '0;
  assign out_index = out_valid ? idx    : '0;
  assign out_last  = at_last;

endmodule

// File: tb/tb_fft_output_serializer.sv
// Randomized bench: a queue of expected samples per accepted frame is checked
// cycle by cycle against the serializer outputs.
module tb_fft_output_serializer;
  localparam int N  = 64;
  localparam int W  = 16;
  localparam int LG = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           frame_valid = 1'b0;
  logic           bitrev_sel = 1'b0;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] frame_re = '0;
  logic [N*W-1:0] frame_im = '0;
  logic           frame_ready, out_valid, out_last, busy;
  logic [W-1:0]   out_re, out_im;
  logic [LG-1:0]  out_index;

  fft_output_serializer dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_re(frame_re), .frame_im(frame_im), .bitrev_sel(bitrev_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        idx;
    logic [15:0] re;
    logic [15:0] im;
  } samp_t;

  samp_t q[$];
  int checks = 0, errors = 0;
  int pops = 0, accepts = 0, vrun = 0, vrun_max = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reverse LG bits arithmetically: peel bits LSB-first, push into result MSB-first.
  function automatic int rev(input int i);
    int r = 0;
    for (int b = 0; b < LG; b++) r = r * 2 + ((i >> b) & 1);
    return r;
  endfunction

  // One clock: check outputs against the model at negedge, advance model at posedge.
  task automatic step();
    logic   exp_ready, hs_out, hs_in, r_n, bsel;
    logic [N*W-1:0] cre, cim;
    samp_t  s;
    @(negedge clk);
    exp_ready = (q.size() == 0) || (out_ready && q.size() == 1);
    chk("frame_ready", 32'(frame_ready), 32'(exp_ready));
    chk("busy",        32'(busy),        32'(q.size() != 0));
    chk("out_valid",   32'(out_valid),   32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_index", 32'(out_index), 32'(q[0].idx));
      chk("out_re",    32'(out_re),    32'(q[0].re));
      chk("out_im",    32'(out_im),    32'(q[0].im));
      chk("out_last",  32'(out_last),  32'(q.size() == 1));
      vrun++;
      if (vrun > vrun_max) vrun_max = vrun;
    end else begin
      chk("idle_zero", {out_re, out_im}, 32'd0);
      chk("idle_idx_last", {out_index, out_last}, 32'd0);
      vrun = 0;
    end
    hs_out = (q.size() != 0) && out_ready;
    hs_in  = frame_valid && exp_ready;
    r_n = rst_n; bsel = bitrev_sel; cre = frame_re; cim = frame_im;
    @(posedge clk);
    if (!r_n) q.delete();
    else begin
      if (hs_out) begin void'(q.pop_front()); pops++; end
      if (hs_in) begin
        accepts++;
        for (int i = 0; i < N; i++) begin
          s.idx = bsel ? rev(i) : i;
          s.re  = cre[s.idx*W +: W];
          s.im  = cim[s.idx*W +: W];
          q.push_back(s);
        end
      end
    end
    #1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < N; k++) begin
      frame_re[k*W +: W] = 16'(k);
      frame_im[k*W +: W] = 16'(-k);
    end
  endtask

  task automatic load_rand();
    for (int k = 0; k < N; k++) begin
      frame_re[k*W +: W] = 16'($urandom);
      frame_im[k*W +: W] = 16'($urandom);
    end
  endtask

  task automatic send_frame(input logic bsel);
    int a0 = accepts;
    int n = 0;
    frame_valid = 1'b1;
    bitrev_sel  = bsel;
    while (accepts == a0 && n < 300) begin step(); n++; end
    chk("accept_timeout", 32'(accepts - a0), 32'd1);
    frame_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(); n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    int p0;
    repeat (2) @(posedge clk);
    #1;
    step();                       // reset held: idle outputs
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;

    // Ramp frame, natural order
    load_ramp(); p0 = pops;
    send_frame(1'b0); drain(1'b0);
    chk("ramp_pops", 32'(pops - p0), 32'd64);

    // Ramp frame, bit-reversed order
    p0 = pops;
    send_frame(1'b1); drain(1'b0);
    chk("brev_pops", 32'(pops - p0), 32'd64);

    // Random data with 50% backpressure
    load_rand(); p0 = pops;
    send_frame(1'($urandom_range(0, 1))); drain(1'b1);
    chk("stall_pops", 32'(pops - p0), 32'd64);

    // Back-to-back frames with frame_valid held
    load_ramp(); vrun_max = 0; p0 = accepts;
    frame_valid = 1'b1; bitrev_sel = 1'b0;
    for (int n = 0; n < 300 && accepts - p0 < 2; n++) step();
    frame_valid = 1'b0;
    drain(1'b0);
    chk("b2b_accepts", 32'(accepts - p0), 32'd2);
    chk("b2b_run", 32'(vrun_max), 32'd128);

    // Reset after the 10th sample abandons the frame
    load_rand(); send_frame(1'b0); p0 = pops;
    for (int n = 0; n < 100 && pops - p0 < 10; n++) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    step();
    load_rand(); p0 = pops;
    send_frame(1'b1); drain(1'b0);
    chk("post_reset_pops", 32'(pops - p0), 32'd64);

    // Frame pulsed mid-stream with other data is ignored
    load_rand(); p0 = accepts;
    send_frame(1'b0);
    repeat (5) step();
    load_rand(); frame_valid = 1'b1; bitrev_sel = 1'b1;
    repeat (3) step();
    frame_valid = 1'b0;
    drain(1'b0);
    chk("ignored_accepts", 32'(accepts - p0), 32'd1);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      frame_valid = ($urandom_range(0, 9) < 3);
      out_ready   = 1'($urandom_range(0, 1));
      bitrev_sel  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) load_rand();
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end
    frame_valid = 1'b0;
    drain(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
